// File: rtl/ascon_decrypt_fsm.sv
// ascon_decrypt_fsm
// Sequencer for ASCON-128 decryption of one fixed-size message made of
// N_BLOCKS 64-bit ciphertext blocks plus one 64-bit associated-data block.
// It drives the core handshake in decrypt mode, collects the recovered
// plaintext blocks in a register and checks the core's tag against tag_i.
//
// Optional build macro: ASCON_DEC_PT_GATE_EN
//   defined   : plaintext output reads 0 while busy, and the buffer is wiped
//               in DONE when the tag did not match.
//   undefined : plaintext output always shows the captured blocks.
//
// Ports
//   clock_i, reset_i              clock (rising edge), async active-high reset
//   start_i                       start a decryption (sampled in IDLE only)
//   cipher_i, tag_i, da_i         ciphertext (block 0 in the MSBs), received tag, AD
//   plain_text_o                  recovered plaintext, same block ordering
//   tag_ok_o, done_o, busy_o      tag result, one-cycle done pulse, busy flag
//   core_*_o                      Moore-decoded control/data to the ASCON core
//   core_*_i                      handshake, output block and tag from the core
module ascon_decrypt_fsm #(
  parameter int N_BLOCKS = 23,
  parameter int CNT_W    = 5
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [64*N_BLOCKS-1:0] cipher_i,
  input  logic [127:0]          tag_i,
  input  logic [63:0]           da_i,
  output logic [64*N_BLOCKS-1:0] plain_text_o,
  output logic                  tag_ok_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  core_init_o,
  output logic                  core_associate_data_o,
  output logic                  core_finalisation_o,
  output logic                  core_decrypt_o,
  output logic [63:0]           core_data_o,
  output logic                  core_data_valid_o,
  input  logic                  core_end_initialisation_i,
  input  logic                  core_end_associate_i,
  input  logic [63:0]           core_data_i,
  input  logic                  core_data_valid_i,
  input  logic                  core_end_cipher_i,
  input  logic                  core_end_tag_i,
  input  logic [127:0]          core_tag_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_WAIT_INIT, S_AD_LOAD, S_AD_WAIT,
    S_CT_LOAD, S_CT_WAIT, S_FINAL_LOAD, S_FINAL_WAIT, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BLOCKS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_tag_ok;
  logic [63:0]      r_blk [N_BLOCKS];
  logic [63:0]      w_ct_blk;
  logic             w_capture;
  logic [64*N_BLOCKS-1:0] w_pt_packed;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_capture = ((r_state == S_CT_WAIT) || (r_state == S_FINAL_WAIT)) && core_data_valid_i;

  // State register; reset aborts any transfer in progress.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic. A one-block message skips the ciphertext loop and
  // goes straight to the finalisation block.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (start_i) w_next = S_INIT;
      S_INIT:       w_next = S_WAIT_INIT;
      S_WAIT_INIT:  if (core_end_initialisation_i) w_next = S_AD_LOAD;
      S_AD_LOAD:    w_next = S_AD_WAIT;
      S_AD_WAIT:    if (core_end_associate_i) w_next = (N_BLOCKS > 1) ? S_CT_LOAD : S_FINAL_LOAD;
      S_CT_LOAD:    w_next = S_CT_WAIT;
      S_CT_WAIT:    if (core_end_cipher_i) w_next = (w_cnt_inc == LAST_IDX) ? S_FINAL_LOAD : S_CT_LOAD;
      S_FINAL_LOAD: w_next = S_FINAL_WAIT;
      S_FINAL_WAIT: if (core_end_tag_i) w_next = S_DONE;
      S_DONE:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // Block counter and tag verdict. The counter only advances while it is
  // below the last index, so it can never walk off the end of the message.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_cnt    <= '0;
      r_tag_ok <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start_i) begin
        r_cnt    <= '0;
        r_tag_ok <= 1'b0;
      end
      if (r_state == S_CT_WAIT && core_end_cipher_i && r_cnt != LAST_IDX)
        r_cnt <= w_cnt_inc;
      if (r_state == S_FINAL_WAIT && core_end_tag_i)
        r_tag_ok <= (core_tag_i == tag_i);
    end
  end

  // Plaintext buffer. A returned block lands at the current counter value,
  // which is still the old index when valid and end-of-block coincide.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < N_BLOCKS; k++) r_blk[k] <= '0;
    end else begin
      for (int k = 0; k < N_BLOCKS; k++) begin
        if (w_capture && r_cnt == CNT_W'(k)) r_blk[k] <= core_data_i;
`ifdef ASCON_DEC_PT_GATE_EN
        if (r_state == S_DONE && !r_tag_ok) r_blk[k] <= '0;
`endif
      end
    end
  end

  // Ciphertext block selection; an index outside the message yields zero.
  always_comb begin
    w_ct_blk = '0;
    for (int k = 0; k < N_BLOCKS; k++)
      if (r_cnt == CNT_W'(k)) w_ct_blk = cipher_i[64*(N_BLOCKS-k)-1 -: 64];
  end

  // Pack the buffer back into the flat output ordering (block 0 in the MSBs).
  always_comb begin
    w_pt_packed = '0;
    for (int k = 0; k < N_BLOCKS; k++)
      w_pt_packed[64*(N_BLOCKS-k)-1 -: 64] = r_blk[k];
  end

`ifdef ASCON_DEC_PT_GATE_EN
  assign plain_text_o = busy_o ? '0 : w_pt_packed;
`else
  assign plain_text_o = w_pt_packed;
`endif

  assign tag_ok_o = r_tag_ok;

  // Moore output decode: every core strobe depends on the state alone.
  always_comb begin
    done_o                = 1'b0;
    busy_o                = (r_state != S_IDLE);
    core_init_o           = 1'b0;
    core_associate_data_o = 1'b0;
    core_finalisation_o   = 1'b0;
    core_decrypt_o        = 1'b0;
    core_data_o           = '0;
    core_data_valid_o     = 1'b0;
    case (r_state)
      S_INIT: core_init_o = 1'b1;
      S_AD_LOAD: begin
        core_init_o           = 1'b1;
        core_associate_data_o = 1'b1;
        core_data_valid_o     = 1'b1;
        core_data_o           = da_i;
      end
      S_CT_LOAD: begin
        core_decrypt_o    = 1'b1;
        core_data_valid_o = 1'b1;
        core_data_o       = w_ct_blk;
      end
      S_CT_WAIT: core_decrypt_o = 1'b1;
      S_FINAL_LOAD: begin
        core_decrypt_o      = 1'b1;
        core_finalisation_o = 1'b1;
        core_data_valid_o   = 1'b1;
        core_data_o         = cipher_i[63:0];
      end
      S_FINAL_WAIT: core_decrypt_o = 1'b1;
      S_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ascon_decrypt_fsm.sv
// tb_ascon_decrypt_fsm
// Randomised bench for ascon_decrypt_fsm. A behavioural core model answers
// the sequencer's strobes (output block = input block XOR A5A5..., fixed tag)
// and a reference of the expected plaintext is built directly from the
// ciphertext array. Honours ASCON_DEC_PT_GATE_EN when it is defined.
module tb_ascon_decrypt_fsm;

  localparam int          N        = 23;
  localparam logic [63:0]  XMASK    = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [127:0] CORE_TAG = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

  logic             clock_i = 1'b0;
  logic             reset_i = 1'b1;
  logic             start_i = 1'b0;
  logic [64*N-1:0]  cipher_i = '0;
  logic [127:0]     tag_i = '0;
  logic [63:0]      da_i = '0;
  logic [64*N-1:0]  plain_text_o;
  logic             tag_ok_o, done_o, busy_o;
  logic             core_init_o, core_associate_data_o, core_finalisation_o;
  logic             core_decrypt_o, core_data_valid_o;
  logic [63:0]      core_data_o;
  logic             core_end_initialisation_i = 1'b0;
  logic             core_end_associate_i = 1'b0;
  logic [63:0]      core_data_i = '0;
  logic             core_data_valid_i = 1'b0;
  logic             core_end_cipher_i = 1'b0;
  logic             core_end_tag_i = 1'b0;
  logic [127:0]     core_tag_i = CORE_TAG;

  ascon_decrypt_fsm dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i),
    .cipher_i(cipher_i), .tag_i(tag_i), .da_i(da_i),
    .plain_text_o(plain_text_o), .tag_ok_o(tag_ok_o), .done_o(done_o), .busy_o(busy_o),
    .core_init_o(core_init_o), .core_associate_data_o(core_associate_data_o),
    .core_finalisation_o(core_finalisation_o), .core_decrypt_o(core_decrypt_o),
    .core_data_o(core_data_o), .core_data_valid_o(core_data_valid_o),
    .core_end_initialisation_i(core_end_initialisation_i),
    .core_end_associate_i(core_end_associate_i),
    .core_data_i(core_data_i), .core_data_valid_i(core_data_valid_i),
    .core_end_cipher_i(core_end_cipher_i), .core_end_tag_i(core_end_tag_i),
    .core_tag_i(core_tag_i)
  );

  // Free-running 10 ns clock.
  always #5 clock_i = ~clock_i;

  int          vecCount = 0;
  int          missCount = 0;
  logic [63:0] cipherBlk [N];
  logic [63:0] daVal;
  int          delayMode = 0;
  bit          coincide = 1'b0;
  int          blkIdx = 0;
  int          initCnt, validCnt, finCnt, doneCnt;

  // Single comparison point: counts the vector and reports a miscompare.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic int pickDelay();
    case (delayMode)
      0:       return 0;
      1:       return 20;
      default: return int'($urandom_range(0, 5));
    endcase
  endfunction

  task automatic waitCycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clock_i);
      #1;
    end
  endtask

  // Called 1 time unit after a rising edge; moves into the sequencer's wait
  // state and then applies the chosen core latency.
  task automatic enterWait();
    @(posedge clock_i); #1;
    waitCycles(pickDelay());
  endtask

  // Returns the block the core would produce, then the end-of-block event.
  task automatic returnBlock(input logic [63:0] inBlk, input bit isFinal);
    core_data_i = inBlk ^ XMASK;
    if (coincide) begin
      core_data_valid_i = 1'b1;
      if (isFinal) core_end_tag_i = 1'b1; else core_end_cipher_i = 1'b1;
      @(posedge clock_i); #1;
      core_data_valid_i = 1'b0; core_end_tag_i = 1'b0; core_end_cipher_i = 1'b0;
    end else begin
      core_data_valid_i = 1'b1;
      @(posedge clock_i); #1;
      core_data_valid_i = 1'b0;
      waitCycles(pickDelay());
      if (isFinal) core_end_tag_i = 1'b1; else core_end_cipher_i = 1'b1;
      @(posedge clock_i); #1;
      core_end_tag_i = 1'b0; core_end_cipher_i = 1'b0;
    end
  endtask

  // Serves one strobe of the sequencer if one is present right now.
  task automatic handleOne(output bit handled);
    logic [63:0] inBlk;
    handled = 1'b1;
    if (reset_i) handled = 1'b0;
    else if (core_init_o && !core_associate_data_o) begin
      blkIdx = 0;
      enterWait();
      core_end_initialisation_i = 1'b1;
      @(posedge clock_i); #1;
      core_end_initialisation_i = 1'b0;
    end else if (core_associate_data_o) begin
      checkOutput("ad_data", core_data_o, daVal);
      enterWait();
      core_end_associate_i = 1'b1;
      @(posedge clock_i); #1;
      core_end_associate_i = 1'b0;
    end else if (core_data_valid_o && core_finalisation_o) begin
      inBlk = core_data_o;
      checkOutput("final_block", inBlk, cipherBlk[N-1]);
      enterWait();
      returnBlock(inBlk, 1'b1);
    end else if (core_data_valid_o) begin
      inBlk = core_data_o;
      checkOutput("ct_block", inBlk, cipherBlk[(blkIdx < N-1) ? blkIdx : N-1]);
      blkIdx++;
      enterWait();
      returnBlock(inBlk, 1'b0);
    end else handled = 1'b0;
  endtask

  // Behavioural ASCON core: reacts to strobes seen just after each edge.
  initial begin
    bit handled;
    forever begin
      @(posedge clock_i); #1;
      do handleOne(handled); while (handled);
    end
  end

  // Runs one decryption and checks it against the reference; abortAt >= 0
  // asserts reset while block abortAt is in flight.
  task automatic applyStimulus(input bit badTag, input int dMode, input bit coin,
                               input bit extraStarts, input int abortAt, input bit patterned);
    bit          gotDone, aborted, abortNext;
    logic [63:0] expBlk;
    delayMode = dMode;
    coincide  = coin;
    for (int k = 0; k < N; k++) begin
      cipherBlk[k] = patterned ? {32'(k), 32'(k)} : {$urandom, $urandom};
      cipher_i[64*(N-k)-1 -: 64] = cipherBlk[k];
    end
    daVal = {$urandom, $urandom};
    da_i  = daVal;
    tag_i = CORE_TAG ^ {127'b0, badTag};
    initCnt = 0; validCnt = 0; finCnt = 0; doneCnt = 0;
    gotDone = 1'b0; aborted = 1'b0; abortNext = 1'b0;
    @(negedge clock_i);
    start_i = 1'b1;
    for (int cyc = 0; cyc < 4000 && !gotDone && !aborted; cyc++) begin
      @(negedge clock_i);
      start_i = extraStarts && (cyc % 29 == 3);
      if (abortNext) begin
        reset_i = 1'b1;
        #1;
        checkOutput("rst_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_done", 64'(done_o), 64'd0);
        checkOutput("rst_tag_ok", 64'(tag_ok_o), 64'd0);
        checkOutput("rst_valid", 64'(core_data_valid_o), 64'd0);
        checkOutput("rst_decrypt", 64'(core_decrypt_o), 64'd0);
        checkOutput("rst_data", core_data_o, 64'd0);
        checkOutput("rst_plaintext", 64'(|plain_text_o), 64'd0);
        aborted = 1'b1;
      end else begin
        if (core_init_o && !core_associate_data_o) initCnt++;
        if (core_data_valid_o && core_decrypt_o) validCnt++;
        if (core_finalisation_o) finCnt++;
        if (core_data_valid_o && core_decrypt_o && !core_finalisation_o && validCnt == abortAt + 1)
          abortNext = 1'b1;
`ifdef ASCON_DEC_PT_GATE_EN
        if (validCnt == 6 && core_data_valid_o)
          checkOutput("pt_hidden_busy", 64'(|plain_text_o), 64'd0);
`endif
        if (done_o) begin
          doneCnt++;
          gotDone = 1'b1;
          checkOutput("busy_at_done", 64'(busy_o), 64'd1);
        end
      end
    end
    start_i = 1'b0;
    if (aborted) begin
      @(negedge clock_i);
      reset_i = 1'b0;
      repeat (60) @(negedge clock_i);
      checkOutput("idle_after_rst", 64'(busy_o), 64'd0);
    end else begin
      checkOutput("done_seen", 64'(gotDone), 64'd1);
      if (gotDone) begin
        @(negedge clock_i);
        checkOutput("busy_after_done", 64'(busy_o), 64'd0);
        repeat (5) begin
          if (done_o) doneCnt++;
          @(negedge clock_i);
        end
        checkOutput("done_pulses", 64'(doneCnt), 64'd1);
        checkOutput("init_count", 64'(initCnt), 64'd1);
        checkOutput("valid_count", 64'(validCnt), 64'(N));
        checkOutput("final_count", 64'(finCnt), 64'd1);
        checkOutput("tag_ok", 64'(tag_ok_o), 64'(!badTag));
        for (int k = 0; k < N; k++) begin
`ifdef ASCON_DEC_PT_GATE_EN
          expBlk = badTag ? 64'd0 : (cipherBlk[k] ^ XMASK);
`else
          expBlk = cipherBlk[k] ^ XMASK;
`endif
          checkOutput($sformatf("pt_blk%0d", k), plain_text_o[64*(N-k)-1 -: 64], expBlk);
        end
      end
    end
  endtask

  initial begin
    #1;
    checkOutput("reset_busy", 64'(busy_o), 64'd0);
    checkOutput("reset_tag_ok", 64'(tag_ok_o), 64'd0);
    checkOutput("reset_plaintext", 64'(|plain_text_o), 64'd0);
    checkOutput("reset_init", 64'(core_init_o), 64'd0);
    repeat (3) @(negedge clock_i);
    reset_i = 1'b0;
    @(negedge clock_i);

    applyStimulus(1'b0, 0, 1'b0, 1'b0, -1, 1'b1);
    applyStimulus(1'b1, 0, 1'b0, 1'b0, -1, 1'b1);
    applyStimulus(1'b0, 2, 1'b1, 1'b0, -1, 1'b0);
    applyStimulus(1'b0, 2, 1'b0, 1'b0, 10, 1'b0);
    applyStimulus(1'b0, 2, 1'b0, 1'b0, -1, 1'b0);
    applyStimulus(1'b0, 2, 1'b0, 1'b1, -1, 1'b0);
    applyStimulus(1'b0, 1, 1'b0, 1'b0, -1, 1'b1);
    applyStimulus(1'b0, 1, 1'b1, 1'b0, -1, 1'b1);
    for (int r = 0; r < 4; r++)
      applyStimulus(1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/ascon_decrypt_fsm.md
Name: ascon_decrypt_fsm

Overview:
Sequencer for ASCON-128 decryption of one fixed-size 1472-bit message (23 x 64-bit blocks) with one 64-bit associated-data block. It is the receive-side counterpart of the encryption sequencer. It drives the ASCON core's control/data handshake in decrypt mode and assembles the recovered plaintext in a register. It then compares the core's computed tag against the received tag and reports pass/fail.

Parameters:
N_BLOCKS, 23, number of 64-bit data blocks; block N_BLOCKS-1 is sent with finalisation.
CNT_W, 5, block counter width; must satisfy 2**CNT_W > N_BLOCKS.

Ports:
clock_i  in  1  system clock, rising edge
reset_i  in  1  asynchronous reset, active-high
start_i  in  1  start one decryption; sampled only in IDLE
cipher_i  in  64*N_BLOCKS  ciphertext; block k = bits [64*(N_BLOCKS-k)-1 -: 64]
tag_i  in  128  received tag
da_i  in  64  associated data block
plain_text_o  out  64*N_BLOCKS  recovered plaintext register, same block ordering
tag_ok_o  out  1  registered; 1 = computed tag equals tag_i
done_o  out  1  one-cycle pulse when result is final
busy_o  out  1  high in every state except IDLE
core_init_o  out  1  to core init_i
core_associate_data_o  out  1  to core associate_data_i
core_finalisation_o  out  1  to core finalisation_i
core_decrypt_o  out  1  decrypt mode select; high from CT_LOAD through FINAL_WAIT
core_data_o  out  64  to core data_i
core_data_valid_o  out  1  to core data_valid_i
core_end_initialisation_i  in  1  from core
core_end_associate_i  in  1  from core
core_data_i  in  64  core output block (plaintext in decrypt mode)
core_data_valid_i  in  1  core output block valid
core_end_cipher_i  in  1  core finished current block
core_end_tag_i  in  1  tag ready
core_tag_i  in  128  computed tag

Behaviour:
- Reset (async, reset_i=1): state IDLE; counter 0; plain_text_o 0; tag_ok_o 0; done_o 0; busy_o 0; all core_* outputs 0. Reset mid-operation aborts immediately. There is no resume.
- Core outputs are decoded from the current state only (Moore). All strobes below last exactly one cycle.
- IDLE: if start_i, clear counter and tag_ok_o, then go to INIT. Otherwise stay. start_i is ignored in every other state.
- INIT: core_init_o=1 -> WAIT_INIT.
- WAIT_INIT: wait for core_end_initialisation_i -> AD_LOAD.
- AD_LOAD: core_init_o=1, core_associate_data_o=1, core_data_valid_o=1, core_data_o=da_i -> AD_WAIT.
- AD_WAIT: wait for core_end_associate_i -> CT_LOAD.
- CT_LOAD: core_data_o = cipher block[counter], core_data_valid_o=1 -> CT_WAIT.
- CT_WAIT:
  - core_data_valid_i=1 writes core_data_i into plain_text_o block[counter] (registered).
  - core_end_cipher_i=1 increments the counter. If the new counter equals N_BLOCKS-1, go to FINAL_LOAD; otherwise go to CT_LOAD.
  - If valid and end arrive in the same cycle, capture into the old index, then increment.
- FINAL_LOAD: core_finalisation_o=1, core_data_valid_o=1, core_data_o = block[N_BLOCKS-1] -> FINAL_WAIT.
- FINAL_WAIT:
  - core_data_valid_i captures block[N_BLOCKS-1].
  - core_end_tag_i registers tag_ok_o = (core_tag_i == tag_i) -> DONE.
  - If core_end_tag_i and core_data_valid_i coincide, both take effect.
- DONE: done_o=1 for one cycle, busy_o=1 -> IDLE. plain_text_o and tag_ok_o hold until the next start.
- Counter never exceeds N_BLOCKS-1. Out-of-range indices drive core_data_o=0.
- All plaintext writes are clocked. No latches.

Optional Feature:
ASCON_DEC_PT_GATE_EN
- Defined: in DONE, if tag_ok_o=0, plain_text_o is cleared to 0 (unauthenticated data never released). During operation, plain_text_o reads 0 while busy_o=1; the internal buffer is used for capture.
- Undefined: plain_text_o always reflects captured blocks, regardless of the tag result.

Test Plan:
1. Core model returns data XOR 64'hA5A5_A5A5_A5A5_A5A5 and tag 128'h0123...CDEF; tag_i matches; cipher block k = {k,k}; start -> plain_text block k = {k,k}^A5A5..., tag_ok_o=1, exactly one done_o pulse, 23 core_data_valid_o pulses (the last with finalisation).
2. Same stimulus with tag_i bit 0 flipped -> tag_ok_o=0. With ASCON_DEC_PT_GATE_EN, plain_text_o=0 after done; without it, plaintext is as in test 1.
3. Core model asserts core_data_valid_i and core_end_cipher_i in the same cycle for every block -> every block is captured at the correct index, with no skip or duplicate.
4. Assert reset_i at block 10 in CT_WAIT -> all outputs 0 on the same edge, busy_o=0. A new start then completes correctly.
5. Pulse start_i while busy -> no effect. Core init is issued only once, and done_o pulses once.
6. Core delays each end_* by 0 and by 20 cycles -> FSM waits with core strobes low, and the results are identical.
